// File: rtl/renderer_pkg.sv
// Shared types and constants for the sprite rectangle renderer.
package renderer_pkg;

  // Signed object-coordinate width; wide enough for centre offset plus size.
  localparam int unsigned COORD_W = 13;
  // Width of window coordinates, object sizes and raster counters.
  localparam int unsigned SCR_W   = 10;
  // Width of signed centre-relative displacements.
  localparam int unsigned DX_W    = 12;
  // Colour storage width inside an object box (RGB444 in [11:0]).
  localparam int unsigned COLOR_W = 16;

  localparam logic [COLOR_W-1:0] RGB_BLACK = 16'h0000;
  localparam logic [COLOR_W-1:0] RGB_WHITE = 16'h0FFF;
  localparam logic [COLOR_W-1:0] RGB_RED   = 16'h0F00;
  localparam logic [COLOR_W-1:0] RGB_GREEN = 16'h00F0;
  localparam logic [COLOR_W-1:0] RGB_BLUE  = 16'h000F;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Latched screen-space box of one object; x1/y1 are exclusive.
  typedef struct packed {
    logic                       en;
    logic signed [COORD_W-1:0]  x0;
    logic signed [COORD_W-1:0]  x1;
    logic signed [COORD_W-1:0]  y0;
    logic signed [COORD_W-1:0]  y1;
    logic        [COLOR_W-1:0]  color;
  } obj_box_t;

endpackage

// File: rtl/rect_hit_test.sv
// Combinational point-in-rectangle test for one object box.
// Ports: box (latched object box), x/y (current pixel), hit (pixel covered).
module rect_hit_test
  import renderer_pkg::*;
(
  input  obj_box_t           box,
  input  logic [SCR_W-1:0]   x,
  input  logic [SCR_W-1:0]   y,
  output logic               hit
);

  logic signed [COORD_W-1:0] xs;
  logic signed [COORD_W-1:0] ys;
  logic signed [COORD_W-1:0] bx0;
  logic signed [COORD_W-1:0] bx1;
  logic signed [COORD_W-1:0] by0;
  logic signed [COORD_W-1:0] by1;

  // Pixel coordinates are non-negative; zero-extend so the compare stays signed.
  assign xs  = {{(COORD_W-SCR_W){1'b0}}, x};
  assign ys  = {{(COORD_W-SCR_W){1'b0}}, y};
  assign bx0 = box.x0;
  assign bx1 = box.x1;
  assign by0 = box.y0;
  assign by1 = box.y1;

  assign hit = box.en && (bx0 <= xs) && (xs < bx1) && (by0 <= ys) && (ys < by1);

endmodule

// File: rtl/sprite_rect_renderer.sv
// Rasterises N_OBJ solid rectangles over a background colour into a
// ready/valid framebuffer write port, full frame or clipped window.
// Ports: clk, rst (sync, active-high); start/full_mode/win_* control;
// obj_* per-object descriptors; fb_ready in; fb_we/fb_addr/fb_wdata write
// port; busy (not IDLE); done (one-cycle pulse in FINISH).
module sprite_rect_renderer
  import renderer_pkg::*;
#(
  parameter int unsigned          W        = 320,
  parameter int unsigned          H        = 240,
  parameter int unsigned          N_OBJ    = 4,
  parameter int unsigned          PIX_BITS = 16,
  parameter int unsigned          ADDR_W   = 17,
  parameter logic [PIX_BITS-1:0]  BG_COLOR = '0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               full_mode,
  input  logic [SCR_W-1:0]                   win_x0,
  input  logic [SCR_W-1:0]                   win_x1,
  input  logic [SCR_W-1:0]                   win_y0,
  input  logic [SCR_W-1:0]                   win_y1,
  input  logic [N_OBJ-1:0]                   obj_en,
  input  logic [N_OBJ-1:0][DX_W-1:0]         obj_dx,
  input  logic [N_OBJ-1:0][DX_W-1:0]         obj_dy,
  input  logic [N_OBJ-1:0][SCR_W-1:0]        obj_w,
  input  logic [N_OBJ-1:0][SCR_W-1:0]        obj_h,
  input  logic [N_OBJ-1:0][PIX_BITS-1:0]     obj_color,
  input  logic                               fb_ready,
  output logic                               fb_we,
  output logic [ADDR_W-1:0]                  fb_addr,
  output logic [PIX_BITS-1:0]                fb_wdata,
  output logic                               busy,
  output logic                               done
);

  localparam logic [SCR_W-1:0] X_MAX = SCR_W'(W - 1);
  localparam logic [SCR_W-1:0] Y_MAX = SCR_W'(H - 1);

  // Start row base by shift-and-add over the constant width (no multiplier).
  function automatic logic [ADDR_W-1:0] row_base_of(input logic [SCR_W-1:0] yv);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int b = 0; b < 16; b++) begin
      if (((W >> b) & 32'd1) != 32'd0) acc = acc + (ADDR_W'(yv) << b);
    end
    return acc;
  endfunction

  state_t            state_q, state_d;
  logic [SCR_W-1:0]  x_q, x_d, y_q, y_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [SCR_W-1:0]  x0_q, x1_q, y1_q;
  logic              latch;

  obj_box_t          box_q [N_OBJ];
  obj_box_t          box_d [N_OBJ];
  logic [N_OBJ-1:0]  hit;
  logic [PIX_BITS-1:0] pix;

  logic [SCR_W-1:0]  sx0, sx1, sy0, sy1;
  logic              win_empty;

  // Scan bounds as they would be latched this cycle.
  always_comb begin
    if (full_mode) begin
      sx0 = '0;
      sx1 = X_MAX;
      sy0 = '0;
      sy1 = Y_MAX;
    end else begin
      sx0 = win_x0;
      sx1 = (win_x1 > X_MAX) ? X_MAX : win_x1;
      sy0 = win_y0;
      sy1 = (win_y1 > Y_MAX) ? Y_MAX : win_y1;
    end
  end

  assign win_empty = (sx0 > sx1) || (sy0 > sy1);

  // Object boxes in screen space; 13-bit wraparound arithmetic is intended.
  always_comb begin
    for (int i = 0; i < N_OBJ; i++) begin
      box_d[i].en    = obj_en[i];
      box_d[i].x0    = COORD_W'(W / 2) - COORD_W'(obj_w[i] >> 1)
                     + {obj_dx[i][DX_W-1], obj_dx[i]};
      box_d[i].y0    = COORD_W'(H / 2) - COORD_W'(obj_h[i] >> 1)
                     + {obj_dy[i][DX_W-1], obj_dy[i]};
      box_d[i].x1    = box_d[i].x0 + COORD_W'(obj_w[i]);
      box_d[i].y1    = box_d[i].y0 + COORD_W'(obj_h[i]);
      box_d[i].color = COLOR_W'(obj_color[i]);
    end
  end

  // Next-state and raster advance; moves only on an accepted write.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    row_d   = row_q;
    latch   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          latch   = 1'b1;
          x_d     = sx0;
          y_d     = sy0;
          row_d   = row_base_of(sy0);
          state_d = win_empty ? FINISH : RUN;
        end
      end
      RUN: begin
        if (fb_ready) begin
          if (x_q == x1_q) begin
            if (y_q == y1_q) begin
              state_d = FINISH;
            end else begin
              x_d   = x0_q;
              y_d   = y_q + SCR_W'(1);
              row_d = row_q + ADDR_W'(W);
            end
          end else begin
            x_d = x_q + SCR_W'(1);
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
        x_d     = '0;
        y_d     = '0;
        row_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and raster counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      row_q   <= row_d;
    end
  end

  // Render parameters captured at start.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_OBJ; i++) box_q[i] <= '0;
      x0_q <= '0;
      x1_q <= '0;
      y1_q <= '0;
    end else if (latch) begin
      for (int i = 0; i < N_OBJ; i++) box_q[i] <= box_d[i];
      x0_q <= sx0;
      x1_q <= sx1;
      y1_q <= sy1;
    end
  end

  for (genvar g = 0; g < N_OBJ; g++) begin : g_hit
    rect_hit_test u_hit (
      .box (box_q[g]),
      .x   (x_q),
      .y   (y_q),
      .hit (hit[g])
    );
  end

  // Lowest-index hit wins: scan from the top so lower indices overwrite.
  always_comb begin
    pix = BG_COLOR;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (hit[i]) pix = PIX_BITS'(box_q[i].color);
    end
  end

  assign fb_we    = (state_q == RUN);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FINISH);
  assign fb_addr  = row_q + ADDR_W'(x_q);
  assign fb_wdata = (state_q == RUN) ? pix : BG_COLOR;

endmodule

// File: tb/tb_sprite_rect_renderer.sv
// Self-checking bench for sprite_rect_renderer: a pixel-level model predicts
// the write stream for each render; a negedge monitor checks every write.
module tb_sprite_rect_renderer;

  localparam int W  = 320;
  localparam int H  = 240;
  localparam int N  = 4;
  localparam int AW = 17;

  logic                 clk = 1'b0;
  logic                 rst, start, full_mode;
  logic [9:0]           win_x0, win_x1, win_y0, win_y1;
  logic [N-1:0]         obj_en;
  logic [N-1:0][11:0]   obj_dx, obj_dy;
  logic [N-1:0][9:0]    obj_w, obj_h;
  logic [N-1:0][15:0]   obj_color;
  logic                 fb_ready = 1'b1;
  logic                 fb_we, busy, done;
  logic [AW-1:0]        fb_addr;
  logic [15:0]          fb_wdata;

  sprite_rect_renderer #(.W(W), .H(H), .N_OBJ(N), .PIX_BITS(16), .ADDR_W(AW),
                         .BG_COLOR(16'h0000)) dut (
    .clk(clk), .rst(rst), .start(start), .full_mode(full_mode),
    .win_x0(win_x0), .win_x1(win_x1), .win_y0(win_y0), .win_y1(win_y1),
    .obj_en(obj_en), .obj_dx(obj_dx), .obj_dy(obj_dy), .obj_w(obj_w),
    .obj_h(obj_h), .obj_color(obj_color), .fb_ready(fb_ready),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  // ---------------- model ----------------
  int exp_addr[$];
  int exp_data[$];

  function automatic int model_color(input int x, input int y);
    for (int i = 0; i < N; i++) begin
      int dx, dy, w, h, x0, y0;
      dx = $signed(obj_dx[i]);
      dy = $signed(obj_dy[i]);
      w  = int'(obj_w[i]);
      h  = int'(obj_h[i]);
      x0 = W / 2 - w / 2 + dx;
      y0 = H / 2 - h / 2 + dy;
      if (obj_en[i] && x >= x0 && x < x0 + w && y >= y0 && y < y0 + h)
        return int'(obj_color[i]);
    end
    return 0;
  endfunction

  task automatic build_expected(input bit full, input int wx0, input int wx1,
                                input int wy0, input int wy1);
    int xa, xb, ya, yb;
    exp_addr.delete();
    exp_data.delete();
    if (full) begin
      xa = 0; xb = W - 1; ya = 0; yb = H - 1;
    end else begin
      xa = wx0; ya = wy0;
      xb = (wx1 > W - 1) ? W - 1 : wx1;
      yb = (wy1 > H - 1) ? H - 1 : wy1;
    end
    for (int y = ya; y <= yb; y++)
      for (int x = xa; x <= xb; x++) begin
        exp_addr.push_back(y * W + x);
        exp_data.push_back(model_color(x, y));
      end
  endtask

  // ---------------- monitor ----------------
  bit          chk_en = 1'b0;
  bit          rand_ready = 1'b0;
  int          wr_cnt, stall_cnt, first_addr, last_addr;
  logic [15:0] img [W*H];

  always @(posedge clk) begin
    #1;
    fb_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en && fb_we) begin
      chk("wr_range", int'(fb_addr < AW'(W * H)), 1);
      if (exp_addr.size() == 0) begin
        chk("extra_write", int'(fb_addr), -1);
      end else begin
        chk("wr_addr", int'(fb_addr), exp_addr[0]);
        chk("wr_data", int'(fb_wdata), exp_data[0]);
        if (fb_ready) begin
          void'(exp_addr.pop_front());
          void'(exp_data.pop_front());
          if (wr_cnt == 0) first_addr = int'(fb_addr);
          last_addr = int'(fb_addr);
          wr_cnt++;
          if (fb_addr < AW'(W * H)) img[int'(fb_addr)] = fb_wdata;
        end
      end
      if (!fb_ready) stall_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_objs();
    obj_en = '0; obj_dx = '0; obj_dy = '0; obj_w = '0; obj_h = '0; obj_color = '0;
  endtask

  task automatic set_obj(input int i, input int dx, input int dy, input int w,
                         input int h, input int color);
    obj_en[i]    = 1'b1;
    obj_dx[i]    = 12'(dx);
    obj_dy[i]    = 12'(dy);
    obj_w[i]     = 10'(w);
    obj_h[i]     = 10'(h);
    obj_color[i] = 16'(color);
  endtask

  // One render from IDLE; returns cycle index (1 = first cycle after start edge) of done.
  task automatic render(input string nm, input bit full, input int wx0, input int wx1,
                        input int wy0, input int wy1, input bit rnd, input bit poke,
                        output int done_cyc);
    int n_exp, limit;
    logic [N-1:0] en_s;
    logic [15:0]  col_s;
    full_mode = full;
    win_x0 = 10'(wx0); win_x1 = 10'(wx1); win_y0 = 10'(wy0); win_y1 = 10'(wy1);
    build_expected(full, wx0, wx1, wy0, wy1);
    n_exp = exp_addr.size();
    limit = 4 * n_exp + 100;
    wr_cnt = 0; stall_cnt = 0; first_addr = -1; last_addr = -1;
    en_s = obj_en; col_s = obj_color[0];
    rand_ready = rnd;
    chk_en = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_cyc = 0;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk);
      if (poke && n == 4) begin
        start = 1'b1; full_mode = ~full; obj_en = ~en_s; obj_color[0] = 16'h0ABC;
      end
      if (poke && n == 6) begin
        start = 1'b0; full_mode = full; obj_en = en_s; obj_color[0] = col_s;
      end
      if (done) begin
        done_cyc = n;
        chk({nm, "_busy_at_done"}, int'(busy), 1);
        break;
      end
    end
    chk({nm, "_done_seen"}, int'(done_cyc != 0), 1);
    chk({nm, "_latency"}, done_cyc, n_exp + stall_cnt + 1);
    chk({nm, "_writes"}, wr_cnt, n_exp);
    chk({nm, "_leftover"}, exp_addr.size(), 0);
    @(negedge clk);
    chk({nm, "_idle_busy"}, int'(busy), 0);
    chk({nm, "_done_pulse"}, int'(done), 0);
    chk_en = 1'b0;
    rand_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int  dc;
    bit  noisy;
    rst = 1'b1; start = 1'b0; full_mode = 1'b0;
    win_x0 = '0; win_x1 = '0; win_y0 = '0; win_y1 = '0;
    clear_objs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_fb_we", int'(fb_we), 0);
    chk("rst_fb_addr", int'(fb_addr), 0);
    chk("rst_fb_wdata", int'(fb_wdata), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // Full frame, one centred object: box x 116..203, y 98..141.
    set_obj(0, 0, 0, 88, 44, 'h0F22);
    render("full", 1'b1, 0, 0, 0, 0, 1'b0, 1'b0, dc);
    chk("full_write_count", wr_cnt, 76800);
    chk("full_done_cycle", dc, 76801);
    chk("full_pix_center", int'(img[120*320+160]), 'h0F22);
    chk("full_pix_origin", int'(img[0]), 'h0000);
    chk("full_pix_topleft", int'(img[98*320+116]), 'h0F22);
    chk("full_pix_left_out", int'(img[98*320+115]), 'h0000);
    chk("full_pix_botright", int'(img[141*320+203]), 'h0F22);
    chk("full_pix_below", int'(img[142*320+203]), 'h0000);

    // Overlap: obj0 x150..169 y115..124, obj1 x155..174 y118..127.
    clear_objs();
    set_obj(0, 0, 0, 20, 10, 'h0F00);
    set_obj(1, 5, 3, 20, 10, 'h00F0);
    render("ovl", 1'b0, 145, 179, 113, 129, 1'b0, 1'b0, dc);
    chk("ovl_pix_both", int'(img[120*320+160]), 'h0F00);
    chk("ovl_pix_obj1", int'(img[126*320+172]), 'h00F0);
    chk("ovl_pix_bg", int'(img[120*320+149]), 'h0000);
    obj_en[0] = 1'b0;
    render("ovl_en0", 1'b0, 145, 179, 113, 129, 1'b0, 1'b0, dc);
    chk("ovl_en0_pix_both", int'(img[120*320+160]), 'h00F0);
    chk("ovl_en0_pix_obj0only", int'(img[116*320+152]), 'h0000);
    obj_en[0] = 1'b1; obj_w[0] = 10'd0;
    render("ovl_w0", 1'b0, 145, 179, 113, 129, 1'b0, 1'b0, dc);
    chk("ovl_w0_pix_both", int'(img[120*320+160]), 'h00F0);

    // Clipping: obj0 x-84..3, obj1 x316..403 y198..241, obj2 y-52..-9.
    clear_objs();
    set_obj(0, -200, 0, 88, 44, 'h0F00);
    set_obj(1, 200, 100, 88, 44, 'h00F0);
    set_obj(2, 0, -150, 88, 44, 'h000F);
    render("clipl", 1'b0, 0, 9, 95, 100, 1'b0, 1'b0, dc);
    chk("clipl_pix_x3", int'(img[100*320+3]), 'h0F00);
    chk("clipl_pix_x0", int'(img[98*320+0]), 'h0F00);
    chk("clipl_pix_x4", int'(img[100*320+4]), 'h0000);
    chk("clipl_pix_above", int'(img[97*320+3]), 'h0000);
    render("clipr", 1'b0, 310, 1000, 230, 1000, 1'b0, 1'b0, dc);
    chk("clipr_count", wr_cnt, 100);
    chk("clipr_first", first_addr, 230*320+310);
    chk("clipr_last", last_addr, W*H-1);
    chk("clipr_pix_corner", int'(img[239*320+319]), 'h00F0);
    chk("clipr_pix_x316", int'(img[230*320+316]), 'h00F0);
    chk("clipr_pix_x315", int'(img[239*320+315]), 'h0000);
    render("clipt", 1'b0, 150, 169, 0, 3, 1'b0, 1'b0, dc);
    chk("clipt_pix_top", int'(img[160]), 'h0000);

    // Small window and empty windows.
    render("win", 1'b0, 10, 19, 5, 6, 1'b0, 1'b0, dc);
    chk("win_count", wr_cnt, 20);
    chk("win_first", first_addr, 5*320+10);
    chk("win_last", last_addr, 6*320+19);
    chk("win_done_cycle", dc, 21);
    render("empty_x", 1'b0, 20, 10, 5, 6, 1'b0, 1'b0, dc);
    chk("empty_x_done_cycle", dc, 1);
    chk("empty_x_count", wr_cnt, 0);
    render("empty_y", 1'b0, 0, 9, 300, 400, 1'b0, 1'b0, dc);
    chk("empty_y_done_cycle", dc, 1);

    // Random back-pressure plus ignored start / input changes mid-render.
    clear_objs();
    set_obj(0, -30, -5, 30, 12, 'h0F00);
    set_obj(1, -22, -2, 30, 12, 'h00F0);
    set_obj(3, -10, 0, 40, 40, 'h0FFF);
    render("stall", 1'b0, 100, 139, 100, 119, 1'b1, 1'b1, dc);
    chk("stall_seen", int'(stall_cnt > 0), 1);
    chk("stall_count", wr_cnt, 800);

    // Reset mid-render.
    full_mode = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    chk("prerst_busy", int'(busy), 1);
    chk("prerst_we", int'(fb_we), 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("postrst_we", int'(fb_we), 0);
    chk("postrst_busy", int'(busy), 0);
    chk("postrst_done", int'(done), 0);
    chk("postrst_addr", int'(fb_addr), 0);
    noisy = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy || fb_we) noisy = 1'b1;
    end
    chk("postrst_quiet", int'(noisy), 0);
    render("recover", 1'b0, 10, 19, 5, 6, 1'b0, 1'b0, dc);
    chk("recover_done_cycle", dc, 21);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
